// File: rtl/mem_access_stage.sv
// RV32I MEM stage: EX/MEM -> data-memory req/ack transaction -> MEM/WB register.
// Optional build macro MEM_MISALIGN_CHK_EN turns misaligned half/word accesses into a bubble plus a misalign pulse.
module mem_access_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [1:0]      dsize,
    input  logic [2:0]      funct3,
    input  logic [1:0]      mem_rw,
    input  logic [1:0]      mem_to_reg,
    input  logic            reg_write,
    input  logic [4:0]      wreg,
    input  logic [XLEN-1:0] pcp4,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_reg,
    output logic            wb_reg_write,
    output logic            misalign
);

    localparam int unsigned OFF_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;

    // Transaction context captured at issue time
    logic [OFF_W-1:0] off_q;
    logic [1:0]       dsize_q;
    logic             uns_q;
    logic [1:0]       m2r_q;
    logic [4:0]       wreg_q;
    logic             rw_q;
    logic [XLEN-1:0]  pcp4_q;
    logic [XLEN-1:0]  alu_q;

    logic             is_load_c;
    logic             is_store_c;
    logic             is_mem_c;
    logic             misal_c;
    logic [OFF_W-1:0] off_c;
    logic [3:0]       st_be_c;
    logic [XLEN-1:0]  st_wdata_c;
    logic [XLEN-1:0]  byte_sh_c;
    logic [XLEN-1:0]  half_sh_c;
    logic [XLEN-1:0]  load_c;
    logic [XLEN-1:0]  alu_wb_c;
    logic [XLEN-1:0]  busy_wb_c;
    logic [1:0]       unused_funct3;

    assign unused_funct3 = funct3[1:0];
    assign off_c         = alu_result[OFF_W-1:0];
    assign is_load_c     = (mem_rw == 2'b01);
    assign is_store_c    = (mem_rw == 2'b10);
    assign is_mem_c      = is_load_c | is_store_c;

`ifdef MEM_MISALIGN_CHK_EN
    assign misal_c = ((dsize == 2'b01) && off_c[0]) ||
                     (dsize[1] && (off_c != 2'b00));
`else
    assign misal_c = 1'b0;
`endif

    // Stall is combinational so the upstream keep takes effect in the issue cycle
    assign stall = rst && (((state == IDLE) && is_mem_c && !misal_c) ||
                           ((state == BUSY) && !dmem_ack));

    // Store lane steering
    always_comb begin
        st_be_c    = 4'b1111;
        st_wdata_c = store_data;
        case (dsize)
            2'b00: begin
                st_be_c    = 4'b0001 << off_c;
                st_wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_be_c    = 4'b0011 << {off_c[1], 1'b0};
                st_wdata_c = {2{store_data[15:0]}};
            end
            default: begin
                st_be_c    = 4'b1111;
                st_wdata_c = store_data;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension from the latched offset
    assign byte_sh_c = dmem_rdata >> {off_q, 3'b000};
    assign half_sh_c = dmem_rdata >> {off_q[1], 4'b0000};

    always_comb begin
        load_c = dmem_rdata;
        case (dsize_q)
            2'b00: load_c = uns_q ? {24'd0, byte_sh_c[7:0]}
                                  : {{24{byte_sh_c[7]}}, byte_sh_c[7:0]};
            2'b01: load_c = uns_q ? {16'd0, half_sh_c[15:0]}
                                  : {{16{half_sh_c[15]}}, half_sh_c[15:0]};
            default: load_c = dmem_rdata;
        endcase
    end

    assign alu_wb_c  = (mem_to_reg == 2'b10) ? pcp4 : alu_result;
    assign busy_wb_c = (m2r_q == 2'b01) ? load_c :
                       (m2r_q == 2'b10) ? pcp4_q : alu_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            off_q        <= '0;
            dsize_q      <= '0;
            uns_q        <= 1'b0;
            m2r_q        <= '0;
            wreg_q       <= '0;
            rw_q         <= 1'b0;
            pcp4_q       <= '0;
            alu_q        <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            wb_data      <= '0;
            wb_reg       <= '0;
            wb_reg_write <= 1'b0;
            misalign     <= 1'b0;
        end else begin
            misalign <= 1'b0;
            if (state == IDLE) begin
                if (is_mem_c && misal_c) begin
                    wb_reg_write <= 1'b0;
                    misalign     <= 1'b1;
                end else if (is_mem_c) begin
                    off_q        <= off_c;
                    dsize_q      <= dsize;
                    uns_q        <= funct3[2];
                    m2r_q        <= mem_to_reg;
                    wreg_q       <= wreg;
                    rw_q         <= reg_write;
                    pcp4_q       <= pcp4;
                    alu_q        <= alu_result;
                    dmem_req     <= 1'b1;
                    dmem_we      <= is_store_c;
                    dmem_addr    <= {alu_result[XLEN-1:OFF_W], 2'b00};
                    dmem_be      <= is_store_c ? st_be_c : 4'b1111;
                    dmem_wdata   <= is_store_c ? st_wdata_c : '0;
                    wb_reg_write <= 1'b0;
                    state        <= BUSY;
                end else begin
                    wb_reg_write <= reg_write;
                    wb_reg       <= wreg;
                    wb_data      <= alu_wb_c;
                end
            end else begin
                if (dmem_ack) begin
                    dmem_req     <= 1'b0;
                    wb_reg_write <= rw_q;
                    wb_reg       <= wreg_q;
                    wb_data      <= busy_wb_c;
                    state        <= IDLE;
                end else begin
                    wb_reg_write <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model, per-cycle compare on negedge, directed + random ops.
`timescale 1ns/1ps
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_result, store_data, pcp4, dmem_addr, dmem_wdata, dmem_rdata, wb_data;
    logic [1:0]  dsize, mem_rw, mem_to_reg;
    logic [2:0]  funct3;
    logic        reg_write, dmem_req, dmem_we, dmem_ack, stall, wb_reg_write, misalign;
    logic [4:0]  wreg, wb_reg;
    logic [3:0]  dmem_be;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .store_data(store_data),
        .dsize(dsize), .funct3(funct3), .mem_rw(mem_rw), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .wreg(wreg), .pcp4(pcp4), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_data(wb_data), .wb_reg(wb_reg),
        .wb_reg_write(wb_reg_write), .misalign(misalign)
    );

    int checks = 0;
    int failures = 0;
    int stall_seen = 0;
    int stall_base;
    logic chk_en = 1'b0;

    logic        exp_stall, exp_req, exp_we, exp_wb_we, exp_mis;
    logic [31:0] exp_addr, exp_wdata, exp_wb_data;
    logic [3:0]  exp_be;
    logic [4:0]  exp_wb_reg;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Bytes touched by an access: first lane and count
    function automatic int m_first(input logic [1:0] ds, input logic [1:0] off);
        if (ds == 2'd0) return int'(off);
        if (ds == 2'd1) return (off >= 2'd2) ? 2 : 0;
        return 0;
    endfunction

    function automatic int m_len(input logic [1:0] ds);
        return (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] ds, input logic [1:0] off);
        logic [3:0] r = 4'd0;
        for (int i = 0; i < m_len(ds); i++) r[m_first(ds, off) + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] ds, input logic [31:0] sd);
        if (ds == 2'd0) return {24'd0, sd[7:0]} * 32'h0101_0101;
        if (ds == 2'd1) return {16'd0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] ds, input logic [1:0] off,
                                           input logic uns, input logic [31:0] rd);
        longint mask, v;
        mask = (longint'(1) << (8 * m_len(ds))) - 1;
        v = (longint'(rd) >> (8 * m_first(ds, off))) & mask;
        if (!uns && v > (mask >> 1)) v = v - (mask + 1);
        return 32'(v);
    endfunction

    function automatic logic m_mis(input logic [1:0] ds, input logic [1:0] off);
        return (ds == 2'd1 && off[0]) || (ds >= 2'd2 && off != 2'd0);
    endfunction

    // Per-cycle compare against the model's expectations
    always @(negedge clk) begin
        if (chk_en) begin
            if (stall) stall_seen++;
            check32("stall", 32'(stall), 32'(exp_stall));
            check32("dmem_req", 32'(dmem_req), 32'(exp_req));
            check32("misalign", 32'(misalign), 32'(exp_mis));
            check32("wb_reg_write", 32'(wb_reg_write), 32'(exp_wb_we));
            if (exp_req) begin
                check32("dmem_we", 32'(dmem_we), 32'(exp_we));
                check32("dmem_addr", dmem_addr, exp_addr);
                check32("dmem_be", 32'(dmem_be), 32'(exp_be));
                if (exp_we) check32("dmem_wdata", dmem_wdata, exp_wdata);
            end
            if (exp_wb_we) begin
                check32("wb_reg", 32'(wb_reg), 32'(exp_wb_reg));
                check32("wb_data", wb_data, exp_wb_data);
            end
        end
    end

    // Drive one EX/MEM instruction from posedge+1 until its write-back is registered
    task automatic do_op(input logic [1:0] rw, input logic [1:0] ds, input logic [2:0] f3,
                         input logic [1:0] m2r, input logic rwe, input logic [4:0] wr,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc,
                         input int waits, input logic [31:0] rd);
        logic is_mem, mis;
        is_mem = (rw == 2'b01) || (rw == 2'b10);
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
        mis = is_mem && m_mis(ds, alu[1:0]);
`endif
        mem_rw = rw; dsize = ds; funct3 = f3; mem_to_reg = m2r; reg_write = rwe;
        wreg = wr; alu_result = alu; store_data = sd; pcp4 = pc;
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        stall_base = stall_seen;
        if (!is_mem || mis) begin
            exp_stall = 1'b0;
            @(posedge clk); #1;
            exp_req = 1'b0; exp_mis = mis;
            exp_wb_we = mis ? 1'b0 : rwe;
            exp_wb_reg = wr;
            exp_wb_data = (m2r == 2'b10) ? pc : alu;
        end else begin
            exp_stall = 1'b1;
            @(posedge clk); #1;
            exp_req = 1'b1; exp_we = (rw == 2'b10); exp_mis = 1'b0;
            exp_addr = {alu[31:2], 2'b00};
            exp_be = (rw == 2'b10) ? m_be(ds, alu[1:0]) : 4'hF;
            exp_wdata = m_wdata(ds, sd);
            exp_wb_we = 1'b0;
            for (int i = 0; i < waits; i++) begin
                dmem_ack = 1'b0; dmem_rdata = $urandom;
                @(posedge clk); #1;
            end
            cap_addr = dmem_addr; cap_be = dmem_be; cap_wdata = dmem_wdata;
            dmem_ack = 1'b1; dmem_rdata = rd; exp_stall = 1'b0;
            @(posedge clk); #1;
            dmem_ack = 1'b0; exp_req = 1'b0;
            exp_wb_we = rwe; exp_wb_reg = wr;
            exp_wb_data = (m2r == 2'b01) ? m_load(ds, alu[1:0], f3[2], rd) :
                          (m2r == 2'b10) ? pc : alu;
        end
    endtask

    initial begin
        logic [1:0]  r_rw, r_ds, r_m2r;
        logic [31:0] r_sd;
        mem_rw = 2'b00; dsize = 2'b00; funct3 = 3'd0; mem_to_reg = 2'b00; reg_write = 1'b0;
        wreg = 5'd0; alu_result = 32'd0; store_data = 32'd0; pcp4 = 32'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_wb_we = 1'b0; exp_mis = 1'b0;
        exp_addr = 32'd0; exp_wdata = 32'd0; exp_wb_data = 32'd0; exp_be = 4'd0; exp_wb_reg = 5'd0;

        repeat (2) @(posedge clk);
        #1;
        check32("rst_req", 32'(dmem_req), 32'd0);
        check32("rst_be", 32'(dmem_be), 32'd0);
        check32("rst_wb_we", 32'(wb_reg_write), 32'd0);
        check32("rst_wb_data", wb_data, 32'd0);
        check32("rst_misalign", 32'(misalign), 32'd0);
        check32("rst_stall", 32'(stall), 32'd0);
        rst = 1'b1;
        chk_en = 1'b1;

        // ALU write-back
        do_op(2'b00, 2'b10, 3'd0, 2'b00, 1'b1, 5'd5, 32'h0000_1234, 32'd0, 32'd0, 0, 32'd0);
        check32("alu_wb_data", wb_data, 32'h0000_1234);
        check32("alu_wb_reg", 32'(wb_reg), 32'd5);
        check32("alu_wb_we", 32'(wb_reg_write), 32'd1);
        check32("alu_stall_cycles", 32'(stall_seen - stall_base), 32'd0);

        // sb to 0x103 with three wait states
        do_op(2'b10, 2'b00, 3'd0, 2'b00, 1'b0, 5'd0, 32'h0000_0103, 32'h0000_00AB, 32'd0, 3, 32'd0);
        check32("sb_addr", cap_addr, 32'h0000_0100);
        check32("sb_be", 32'(cap_be), 32'h8);
        check32("sb_wdata", cap_wdata, 32'hABAB_ABAB);
        check32("sb_stall_cycles", 32'(stall_seen - stall_base), 32'd4);
        check32("sb_wb_we", 32'(wb_reg_write), 32'd0);

        // lb then lbu from 0x202, zero-wait
        do_op(2'b01, 2'b00, 3'b000, 2'b01, 1'b1, 5'd7, 32'h0000_0202, 32'd0, 32'd0, 0, 32'h0080_0000);
        check32("lb_wb_data", wb_data, 32'hFFFF_FF80);
        check32("lb_stall_cycles", 32'(stall_seen - stall_base), 32'd1);
        do_op(2'b01, 2'b00, 3'b100, 2'b01, 1'b1, 5'd8, 32'h0000_0202, 32'd0, 32'd0, 0, 32'h0080_0000);
        check32("lbu_wb_data", wb_data, 32'h0000_0080);
        check32("lbu_stall_cycles", 32'(stall_seen - stall_base), 32'd1);

        // lh from 0x2, then jal write-back
        do_op(2'b01, 2'b01, 3'b001, 2'b01, 1'b1, 5'd9, 32'h0000_0002, 32'd0, 32'd0, 1, 32'h8001_0000);
        check32("lh_wb_data", wb_data, 32'hFFFF_8001);
        do_op(2'b00, 2'b10, 3'd0, 2'b10, 1'b1, 5'd1, 32'h0000_0FF0, 32'd0, 32'h0000_0044, 0, 32'd0);
        check32("jal_wb_data", wb_data, 32'h0000_0044);

        // lw from misaligned 0x101
        do_op(2'b01, 2'b10, 3'b010, 2'b01, 1'b1, 5'd10, 32'h0000_0101, 32'd0, 32'd0, 0, 32'h1122_3344);
`ifdef MEM_MISALIGN_CHK_EN
        check32("mis_pulse", 32'(misalign), 32'd1);
        check32("mis_req", 32'(dmem_req), 32'd0);
        check32("mis_wb_we", 32'(wb_reg_write), 32'd0);
        check32("mis_stall_cycles", 32'(stall_seen - stall_base), 32'd0);
`else
        check32("lw_trunc_addr", cap_addr, 32'h0000_0100);
        check32("lw_trunc_data", wb_data, 32'h1122_3344);
`endif

        // Randomized instruction mix
        for (int n = 0; n < 400; n++) begin
            r_rw  = 2'($urandom_range(0, 3));
            r_ds  = 2'($urandom_range(0, 3));
            r_m2r = 2'($urandom_range(0, 3));
            r_sd  = $urandom;
            if (r_ds == 2'd0) r_sd = r_sd & 32'h0000_00FF;
            else if (r_ds == 2'd1) r_sd = r_sd & 32'h0000_FFFF;
            do_op(r_rw, r_ds, 3'($urandom_range(0, 7)), r_m2r,
                  (r_rw == 2'b10) ? 1'b0 : 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom, r_sd, $urandom,
                  $urandom_range(0, 3), $urandom);
        end

        // Reset while a load is outstanding
        chk_en = 1'b0;
        mem_rw = 2'b01; dsize = 2'b10; alu_result = 32'h0000_0300; reg_write = 1'b1;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        check32("busy_req", 32'(dmem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check32("midrst_req", 32'(dmem_req), 32'd0);
        check32("midrst_stall", 32'(stall), 32'd0);
        check32("midrst_wb_we", 32'(wb_reg_write), 32'd0);
        mem_rw = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_req = 1'b0; exp_wb_we = 1'b0; exp_mis = 1'b0;
        chk_en = 1'b1;
        do_op(2'b00, 2'b00, 3'd0, 2'b00, 1'b1, 5'd3, 32'hCAFE_0001, 32'd0, 32'd0, 0, 32'd0);
        check32("post_rst_wb_data", wb_data, 32'hCAFE_0001);
        do_op(2'b00, 2'b00, 3'd0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 32'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the 5-stage RV32I pipeline. Consumes the EX/MEM pipeline register (ALU result, store data, dsize, MemRW, write-back controls) and runs a request/acknowledge transaction on the data-memory bus. Handles byte-lane steering, store byte-enables and load sign/zero extension, and selects the write-back value. Outputs the MEM/WB pipeline register and a stall that drives the upstream keep.

Parameters:
XLEN, 32, data/address width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
alu_result  in  32  ALU result; also the effective address for loads and stores
store_data  in  32  store data, already masked to its size in the low bits
dsize  in  2  access size: 00 byte, 01 half, 10 word
funct3  in  3  instruction funct3; bit 2 = unsigned load
mem_rw  in  2  01 load, 10 store, 00/11 no memory access
mem_to_reg  in  2  write-back select: 00 ALU, 01 load data, 10 PC+4
reg_write  in  1  write-back enable
wreg  in  5  destination register
pcp4  in  32  PC+4
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = store
dmem_addr  out  32  word-aligned address {alu_result[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables (loads: 4'b1111)
dmem_ack  in  1  memory accept/complete, one cycle
dmem_rdata  in  32  read word, valid with ack
stall  out  1  hold PC, IF/ID and ID/EX; keep EX/MEM
wb_data  out  32  MEM/WB write-back value
wb_reg  out  5  MEM/WB destination register
wb_reg_write  out  1  MEM/WB write enable
misalign  out  1  misaligned-access pulse (feature only; otherwise tied 0)

Behaviour:
- Reset (async, rst=0): state IDLE. All outputs are 0, including dmem_req, dmem_be and misalign. A transaction in flight is abandoned, and dmem_req drops immediately.
- States: IDLE and BUSY.
- IDLE, mem_rw not in {01,10}:
  - Registers wb_reg_write=reg_write, wb_reg=wreg and wb_data=(mem_to_reg 10 ? pcp4 : alu_result) on the next edge.
  - Latency 1 cycle. stall=0.
- IDLE, load or store:
  - stall=1 (combinational).
  - At the edge: latch byte offset alu_result[1:0], dsize, funct3[2], mem_to_reg, wreg, reg_write and pcp4.
  - At the same edge: register dmem_req=1, dmem_we, dmem_addr, dmem_be, dmem_wdata, and move to BUSY.
  - The MEM/WB slot gets a bubble (wb_reg_write=0).
- BUSY:
  - Bus outputs are held stable while dmem_req=1.
  - stall = !dmem_ack.
  - Each cycle without ack inserts a bubble.
  - On ack, at the edge: dmem_req=0, write-back is registered, state goes to IDLE.
- Back-to-back accesses: the first IDLE cycle after ack re-evaluates the new EX/MEM contents. Minimum 2 cycles per memory op with zero-wait memory.
- Store steering:
  - byte: be = 4'b0001<<off, wdata = {4{store_data[7:0]}}.
  - half: be = 4'b0011<<{off[1],1'b0}, wdata = {2{store_data[15:0]}}.
  - word: be = 4'b1111, wdata = store_data.
- Load extraction uses the lane selected by the latched offset.
  - byte: sign- or zero-extend bits [8*off+7 : 8*off].
  - half: lane off[1].
  - word: whole word.
  - Zero-extend when funct3[2]=1, otherwise sign-extend.
- Write-back on ack:
  - wb_data = mem_to_reg 01 ? extended load : 10 ? pcp4 : alu_result.
  - wb_reg_write = latched reg_write; stores carry reg_write=0.
- Without the feature, misaligned offsets are truncated: half uses off[1] only, word ignores off.
- dsize=11 is treated as word.
- dmem_ack outside BUSY is ignored.
- dmem_rdata is sampled only in the ack cycle.

Optional Feature:
MEM_MISALIGN_CHK_EN
- Defined: a half access with off[0]=1, or a word access with off≠0, is detected in IDLE. No bus request is issued and stall stays 0. misalign pulses for 1 cycle, and MEM/WB gets a bubble (wb_reg_write=0).
- Undefined: misalign is constant 0 and truncation applies.

Test Plan:
- Reset mid-BUSY (dmem_req=1), then rst=0: dmem_req, stall and wb_reg_write all read 0 immediately; state returns to IDLE.
- ALU op alu_result=0x0000_1234, wreg=5, reg_write=1, mem_to_reg=00: next edge gives wb_data=0x1234, wb_reg=5, wb_reg_write=1, with stall=0 throughout.
- sb, addr 0x103, store_data 0xAB, ack after 3 wait cycles: dmem_addr=0x100, be=4'b1000, wdata=0xABABABAB. stall is high for 4 cycles, and wb_reg_write stays 0.
- lb then lbu from addr 0x202, dmem_rdata=0x00800000, zero-wait: wb_data is 0xFFFFFF80 for lb, then 0x00000080 for lbu. Back-to-back, each op takes 2 cycles.
- lh from addr 0x2, rdata=0x8001_0000: wb_data=0xFFFF8001. jal write-back (mem_to_reg=10, pcp4=0x44) gives wb_data=0x44.
- With MEM_MISALIGN_CHK_EN, lw from addr 0x101: dmem_req stays 0, misalign=1 for one cycle, wb_reg_write=0. Without the macro, the same lw reads word 0x100.
